mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 Port if_req, input, 1 bit: instruction-fetch request; held by the requester until if_gnt.
REQ-005 Port if_addr, input, 32 bits: fetch byte address; sampled in the grant cycle.
REQ-006 Port if_gnt, output, 1 bit: one-cycle pulse marking acceptance of the fetch request.
REQ-007 Port if_rdata, output, 32 bits: fetched word, little-endian.
REQ-008 Port if_rvalid, output, 1 bit: one-cycle pulse marking if_rdata valid.
REQ-009 Port ls_req, input, 1 bit: load/store request; held by the requester until ls_gnt.
REQ-010 Port ls_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 Port ls_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = word.
REQ-012 Port ls_addr, input, 32 bits: byte address.
REQ-013 Port ls_wdata, input, 32 bits: store data.
REQ-014 Ports ls_gnt, ls_rdata and ls_rvalid (outputs, 1, 32 and 1 bits) SHALL behave as the corresponding if_* ports.
REQ-015 Port mem_en, output, 1 bit: byte-memory access strobe.
REQ-016 Port mem_we, output, 1 bit: byte-memory write enable; valid only with mem_en.
REQ-017 Port mem_addr, output, 32 bits: byte-memory address.
REQ-018 Port mem_wdata, output, 8 bits: byte-memory write data.
REQ-019 Port mem_rdata, input, 8 bits: byte-memory read data; valid the cycle after a read strobe.

Function
REQ-020 The FSM SHALL have three states: IDLE, XFER and RESP.
- IDLE -> XFER on a grant.
- XFER -> RESP after N byte accesses.
- RESP -> IDLE unconditionally.
REQ-021 In IDLE with at least one request, the block SHALL pulse exactly one gnt, capture addr/we/size/wdata, and load N.
- N = 4 for fetch.
- N = 1, 2 or 4 for ls_size 0, 1 or 2/3.
REQ-022 When both requests are present in IDLE, the block SHALL grant the port not granted last; a single request SHALL be granted regardless of history.
REQ-023 The last-granted marker SHALL reset to fetch, so the first tie goes to load/store.
REQ-024 For a grant at cycle t, XFER SHALL issue byte k (k = 0..N-1) at cycle t+1+k.
- mem_en = 1.
- mem_addr = captured addr + k, modulo 2^32 (wrap from 0xFFFFFFFF to 0x0).
REQ-025 Store byte k SHALL drive mem_we = 1 and mem_wdata = wdata[8k+7:8k].
REQ-026 Load and fetch byte k SHALL drive mem_we = 0, and the byte sampled from mem_rdata at cycle t+2+k SHALL be placed in rdata[8k+7:8k].
REQ-027 Unused upper rdata bytes SHALL be zero; sign extension is not this block's job.
REQ-028 In RESP (cycle t+N+1), the block SHALL pulse the requester's rvalid with final rdata; stores also pulse ls_rvalid as completion, with ls_rdata = 0.
REQ-029 The earliest next gnt SHALL be cycle t+N+2; no gnt in XFER or RESP; requests arriving then wait.
REQ-030 Misaligned addresses SHALL be served byte-serially without fault.
REQ-031 mem_en SHALL be 0 in IDLE and RESP; mem_addr and mem_wdata are don't-care when mem_en = 0.
REQ-032 rdata outputs SHALL hold their last value until the next rvalid on that port.

Reset
REQ-033 With rst_n = 0 at a clock edge, the block SHALL enter IDLE.
- All outputs go to 0; last-granted goes to fetch; capture registers clear.
REQ-034 A reset in XFER or RESP SHALL abort the transfer: no further mem_en and no rvalid for the aborted request.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the size encoding constants, the state enum and the requester-id constants (IF = 0, LS = 1).
REQ-036 Two-requester round-robin selection SHALL live in a sub-module rr_arbiter2; all else stays in mem_arbiter.

Verification
REQ-037 Fetch only: if_req at cycle 0, if_addr 0x10 with memory bytes 0x10..0x13 = 11,22,33,44.
- if_gnt at cycle 0; mem_addr 0x10..0x13 on cycles 1..4.
- if_rvalid at cycle 5 with if_rdata = 0x44332211.
REQ-038 Store word: ls_addr 0x4, wdata 0xDEADBEEF.
- mem_we bytes EF, BE, AD, DE at 0x4..0x7.
- ls_rvalid at cycle 5.
REQ-039 Tie after reset: both requests at cycle 0.
- ls_gnt at cycle 0; if_gnt at the next IDLE (cycle 6 for a word).
- A second tie then alternates.
REQ-040 Load byte at 0xFFFFFFFF, then load half at 0xFFFFFFFF.
- Byte: ls_rdata = 0x000000XX, rvalid at cycle 2.
- Half: second access at mem_addr 0x0.
REQ-041 Reset asserted at cycle 2 of a word fetch: mem_en is 0 from cycle 3 onward, and there is no if_rvalid.
REQ-042 Requests raised during XFER: no gnt until RESP + 1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port byte-serial memory arbiter.
package mem_arb_pkg;

  // Load/store access size encoding; both 2 and 3 mean a full word.
  localparam logic [1:0] SIZE_BYTE     = 2'd0;
  localparam logic [1:0] SIZE_HALF     = 2'd1;
  localparam logic [1:0] SIZE_WORD     = 2'd2;
  localparam logic [1:0] SIZE_WORD_ALT = 2'd3;

  // Requester identifiers; also the bit position of each port in grant vectors.
  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of byte accesses needed for a load/store of the given size.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and byte-memory bus bundle seen by the arbiter.
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  // Load/store port
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic [31:0] ls_rdata;
  logic        ls_rvalid;
  // Byte-wide memory port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rdata, if_rvalid, ls_gnt, ls_rdata, ls_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_rvalid, ls_gnt, ls_rdata, ls_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selector with its own last-granted marker.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,     // selection allowed this cycle
  input  logic [1:0] i_req,    // bit ID_IF = fetch, bit ID_LS = load/store
  output logic [1:0] o_gnt
);

  logic r_last;

  // Pick a winner: a lone request always wins, a tie goes to the port not granted last.
  always_comb begin
    // NOTE: default assignment first so no path leaves o_gnt unassigned (no latch).
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = (r_last == ID_IF) ? 2'b10 : 2'b01;
      else                o_gnt = i_req;
    end
  end

  // Remember who won; resets to fetch so the first tie goes to load/store.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n)       r_last <= ID_IF;
    else if (|o_gnt)  r_last <= o_gnt[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto a byte-serial memory port.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_e      r_state;
  logic [2:0]  r_cnt;       // index of the byte issued this XFER cycle
  logic [2:0]  r_n;         // bytes in the current transfer
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;       // read bytes collected so far
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;
  logic        r_we;
  logic        r_id;

  logic        w_idle, w_xfer, w_resp;
  logic        w_if_rvalid, w_ls_rvalid;
  logic [1:0]  w_gnt;
  logic [2:0]  w_prev, w_lane;
  logic [31:0] w_final;

  assign w_idle = (r_state == ST_IDLE);
  assign w_xfer = (r_state == ST_XFER);
  assign w_resp = (r_state == ST_RESP);
  assign w_prev = r_cnt - 3'd1;   // byte whose read data arrives this cycle
  assign w_lane = r_n - 3'd1;     // last byte, still on mem_rdata during RESP

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_idle & rst_n),
    .i_req ({bus.ls_req, bus.if_req}),
    .o_gnt (w_gnt)
  );

  // Final response word: collected bytes plus the last byte arriving in RESP; stores return 0.
  always_comb begin
    w_final = r_acc;
    w_final[{w_lane[1:0], 3'b000} +: 8] = bus.mem_rdata;
    if (r_we) w_final = '0;
  end

  assign w_if_rvalid = w_resp & rst_n & (r_id == ID_IF);
  assign w_ls_rvalid = w_resp & rst_n & (r_id == ID_LS);

  assign bus.if_gnt    = w_gnt[ID_IF];
  assign bus.ls_gnt    = w_gnt[ID_LS];
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.ls_rvalid = w_ls_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? w_final : r_if_rdata;
  assign bus.ls_rdata  = w_ls_rvalid ? w_final : r_ls_rdata;

  assign bus.mem_en    = w_xfer;
  assign bus.mem_we    = w_xfer & r_we;
  assign bus.mem_addr  = w_xfer ? (r_addr + {29'd0, r_cnt}) : '0;
  assign bus.mem_wdata = w_xfer ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : '0;

  // IDLE/XFER/RESP sequencer: capture on grant, walk N bytes, then respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_acc      <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
      r_we       <= 1'b0;
      r_id       <= ID_IF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_state <= ST_XFER;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_id    <= w_gnt[ID_LS];
            if (w_gnt[ID_LS]) begin
              r_addr  <= bus.ls_addr;
              r_we    <= bus.ls_we;
              r_wdata <= bus.ls_wdata;
              r_n     <= size_to_n(bus.ls_size);
            end else begin
              r_addr  <= bus.if_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
              r_n     <= 3'd4;
            end
          end
        end
        ST_XFER: begin
          if (!r_we && r_cnt != 3'd0)
            r_acc[{w_prev[1:0], 3'b000} +: 8] <= bus.mem_rdata;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == w_lane) r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (r_id == ID_IF) r_if_rdata <= w_final;
          else               r_ls_rdata <= w_final;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: cycle-timeline reference model plus byte memory responder.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Initial memory content; 0x10..0x13 hold 11,22,33,44.
  function automatic logic [7:0] pat(input logic [31:0] a);
    logic [3:0] nib;
    nib = {2'b00, a[1:0]} + 4'd1;
    if (a[7:2] == 6'h04) return {nib, nib};
    return a[7:0] ^ 8'hA5;
  endfunction

  // Physical byte memory (256-byte alias of the address space).
  logic [7:0] mem    [256];
  bit         mem_wr [256];

  function automatic logic [7:0] phys_rd(input logic [7:0] a);
    return mem_wr[a] ? mem[a] : pat({24'd0, a});
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr[7:0]] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= phys_rd(bus.mem_addr[7:0]);
    else                           bus.mem_rdata <= 8'($urandom);
  end

  // Reference model: memory image and per-cycle expected timeline.
  logic [7:0]  ref_mem [256];
  bit          ref_wr  [256];
  bit          e_en  [4096];
  bit          e_we  [4096];
  logic [31:0] e_addr[4096];
  logic [7:0]  e_wd  [4096];
  bit          e_ifv [4096];
  bit          e_lsv [4096];
  logic [31:0] e_data[4096];
  int          cyc;
  int          free_at;
  bit          last_ls;
  logic [31:0] held_if, held_ls;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Plan one accepted request on the timeline starting at grant cycle c.
  task automatic schedule(input int c, input bit is_ls, input logic [31:0] a,
                          input bit we, input int n, input logic [31:0] wd);
    logic [31:0] val;
    logic [31:0] ak;
    val = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      e_en[c+1+k]   = 1'b1;
      e_we[c+1+k]   = we;
      e_addr[c+1+k] = ak;
      e_wd[c+1+k]   = wd[8*k +: 8];
      if (we) begin
        ref_mem[ak[7:0]] = wd[8*k +: 8];
        ref_wr[ak[7:0]]  = 1'b1;
      end else begin
        val = val | (32'(ref_rd(ak)) << (8*k));
      end
    end
    if (is_ls) e_lsv[c+n+1] = 1'b1;
    else       e_ifv[c+n+1] = 1'b1;
    e_data[c+n+1] = we ? 32'd0 : val;
    free_at = c + n + 2;
    last_ls = is_ls;
  endtask

  // One clock cycle: predict, compare at the falling edge, advance.
  task automatic tick();
    bit g_if, g_ls, xv;
    int n;
    if (cyc > 4000) begin
      $display("FAIL cycle_budget: observed %0d cycles, limit 4000", cyc);
      $fatal(1, "cycle budget exceeded");
    end
    @(negedge clk);
    g_if = 1'b0;
    g_ls = 1'b0;
    if (rst_n && cyc >= free_at && (bus.if_req || bus.ls_req)) begin
      if (bus.if_req && bus.ls_req) begin
        if (last_ls) g_if = 1'b1; else g_ls = 1'b1;
      end else if (bus.if_req) g_if = 1'b1;
      else                     g_ls = 1'b1;
      if (g_if) schedule(cyc, 1'b0, bus.if_addr, 1'b0, 4, 32'd0);
      else begin
        n = (bus.ls_size == 2'd0) ? 1 : (bus.ls_size == 2'd1) ? 2 : 4;
        schedule(cyc, 1'b1, bus.ls_addr, bus.ls_we, n, bus.ls_wdata);
      end
    end
    check("if_gnt", 32'(bus.if_gnt), 32'(g_if));
    check("ls_gnt", 32'(bus.ls_gnt), 32'(g_ls));
    check("mem_en", 32'(bus.mem_en), 32'(e_en[cyc]));
    check("mem_we", 32'(bus.mem_we), 32'(e_en[cyc] && e_we[cyc]));
    if (e_en[cyc]) begin
      check("mem_addr", bus.mem_addr, e_addr[cyc]);
      if (e_we[cyc]) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd[cyc]));
    end
    xv = e_ifv[cyc] && rst_n;
    check("if_rvalid", 32'(bus.if_rvalid), 32'(xv));
    if (xv) held_if = e_data[cyc];
    check("if_rdata", bus.if_rdata, held_if);
    xv = e_lsv[cyc] && rst_n;
    check("ls_rvalid", 32'(bus.ls_rvalid), 32'(xv));
    if (xv) held_ls = e_data[cyc];
    check("ls_rdata", bus.ls_rdata, held_ls);
    @(posedge clk);
    #1;
    if (g_if) bus.if_req = 1'b0;
    if (g_ls) bus.ls_req = 1'b0;
    if (!rst_n) begin
      for (int j = cyc + 1; j < cyc + 8; j++) begin
        e_en[j] = 1'b0; e_we[j] = 1'b0; e_ifv[j] = 1'b0; e_lsv[j] = 1'b0;
      end
      free_at = cyc + 1;
      last_ls = 1'b0;
      held_if = '0;
      held_ls = '0;
    end
    cyc++;
  endtask

  // Run until all requests are served and the model is idle, within a cycle budget.
  task automatic drain();
    bit busy;
    for (int i = 0; i < 40 && (cyc < free_at || bus.if_req || bus.ls_req); i++) tick();
    busy = (cyc < free_at) || bus.if_req || bus.ls_req;
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ls_issue(input bit we, input logic [1:0] size,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = size;
    bus.ls_addr = a; bus.ls_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    cyc = 0; free_at = 0; last_ls = 1'b0; held_if = '0; held_ls = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset_if_rdata", bus.if_rdata, 32'd0);
    check("reset_ls_rdata", bus.ls_rdata, 32'd0);

    // Word fetch from 0x10.
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    drain();
    check("fetch_word", bus.if_rdata, 32'h4433_2211);

    // Store word, then read it back.
    ls_issue(1'b1, 2'd2, 32'h4, 32'hDEAD_BEEF);
    drain();
    check("store_mem", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEAD_BEEF);
    check("store_ls_rdata", bus.ls_rdata, 32'd0);
    ls_issue(1'b0, 2'd3, 32'h4, 32'h0);
    drain();
    check("load_back", bus.ls_rdata, 32'hDEAD_BEEF);

    // Ties after reset: load/store wins first, then alternation.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    ls_issue(1'b0, 2'd2, 32'h30, 32'h0);
    drain();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    ls_issue(1'b1, 2'd1, 32'h50, 32'h1234_5678);
    drain();

    // Address wrap at the top of the space.
    ls_issue(1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0);
    drain();
    check("load_byte_wrap", bus.ls_rdata, 32'h0000_005A);
    ls_issue(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
    drain();
    check("load_half_wrap", bus.ls_rdata, 32'h0000_A55A);

    // Reset two cycles into a word fetch aborts it.
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Requests raised mid-transfer wait for RESP + 1.
    bus.if_req = 1'b1; bus.if_addr = 32'h73;
    tick();
    ls_issue(1'b0, 2'd1, 32'h81, 32'h0);
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h90;
    drain();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = rand_addr();
      end
      if (!bus.ls_req && $urandom_range(0, 2) == 0)
        ls_issue(1'($urandom), 2'($urandom), rand_addr(), $urandom);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
